// File: rtl/multi_timer_unit.sv
// multi_timer_unit: bus-mapped bank of independent up-counting timers.
// Each channel has a reload (TH), a count (TL), a control word (TCON) and a
// prescaler (PRESC). Overflow sets a sticky flag. The flag, gated by IE,
// drives a registered interrupt vector and a combined interrupt line.
module multi_timer_unit #(
  parameter int          N_TIMERS  = 2,
  parameter int          CNT_W     = 32,
  parameter int          PRESC_W   = 16,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [31:0]         Address,
  input  logic [31:0]         Write_data,
  output logic [31:0]         Read_data,
  output logic [N_TIMERS-1:0] irq_vec,
  output logic                irqout
);

  localparam logic [31:0]      STATUS_ADDR = BASE_ADDR + 32'h0000_0080;
  localparam logic [31:0]      CH_SPAN     = 32'(N_TIMERS * 16);
  localparam logic [CNT_W-1:0] CNT_ONES    = {CNT_W{1'b1}};

  // Register offsets inside one 16-byte channel window
  localparam logic [1:0] REG_TH    = 2'd0;
  localparam logic [1:0] REG_TL    = 2'd1;
  localparam logic [1:0] REG_TCON  = 2'd2;
  localparam logic [1:0] REG_PRESC = 2'd3;

  // Architectural state
  logic [CNT_W-1:0]    th_r    [N_TIMERS];
  logic [CNT_W-1:0]    tl_r    [N_TIMERS];
  logic [PRESC_W-1:0]  presc_r [N_TIMERS];
  logic [PRESC_W-1:0]  pcnt_r  [N_TIMERS];
  logic [N_TIMERS-1:0] en_r;
  logic [N_TIMERS-1:0] ie_r;
  logic [N_TIMERS-1:0] os_r;
  logic [N_TIMERS-1:0] flag_r;
  logic [N_TIMERS-1:0] irq_vec_r;
  logic                irqout_r;

  // Next-state values
  logic [CNT_W-1:0]    th_nxt_s    [N_TIMERS];
  logic [CNT_W-1:0]    tl_nxt_s    [N_TIMERS];
  logic [PRESC_W-1:0]  presc_nxt_s [N_TIMERS];
  logic [PRESC_W-1:0]  pcnt_nxt_s  [N_TIMERS];
  logic [N_TIMERS-1:0] en_nxt_s;
  logic [N_TIMERS-1:0] ie_nxt_s;
  logic [N_TIMERS-1:0] os_nxt_s;
  logic [N_TIMERS-1:0] flag_nxt_s;
  logic [N_TIMERS-1:0] irq_nxt_s;

  // Bus decode
  logic [31:0]         off_s;
  logic                ch_hit_s;
  logic                status_hit_s;
  logic [2:0]          ch_s;
  logic [1:0]          reg_s;
  logic [N_TIMERS-1:0] wr_th_s;
  logic [N_TIMERS-1:0] wr_tl_s;
  logic [N_TIMERS-1:0] wr_tcon_s;
  logic [N_TIMERS-1:0] wr_presc_s;
  logic [N_TIMERS-1:0] flag_clr_s;
  logic [N_TIMERS-1:0] tick_s;
  logic [N_TIMERS-1:0] ovf_s;
  logic [31:0]         ch_rd_s [N_TIMERS];
  logic [31:0]         rd_s;

  // Exact address decode: channel window (aligned, existing channel) or STATUS
  always_comb begin
    off_s        = Address - BASE_ADDR;
    ch_hit_s     = (off_s < CH_SPAN) && (off_s[1:0] == 2'b00);
    status_hit_s = (Address == STATUS_ADDR);
    ch_s         = off_s[6:4];
    reg_s        = off_s[3:2];
  end

  // Per-channel write strobes, flag clears, prescaler ticks and overflows
  always_comb begin
    wr_th_s    = {N_TIMERS{1'b0}};
    wr_tl_s    = {N_TIMERS{1'b0}};
    wr_tcon_s  = {N_TIMERS{1'b0}};
    wr_presc_s = {N_TIMERS{1'b0}};
    flag_clr_s = {N_TIMERS{1'b0}};
    tick_s     = {N_TIMERS{1'b0}};
    ovf_s      = {N_TIMERS{1'b0}};
    for (int i = 0; i < N_TIMERS; i++) begin
      wr_th_s[i]    = MemWrite && ch_hit_s && (ch_s == 3'(i)) && (reg_s == REG_TH);
      wr_tl_s[i]    = MemWrite && ch_hit_s && (ch_s == 3'(i)) && (reg_s == REG_TL);
      wr_tcon_s[i]  = MemWrite && ch_hit_s && (ch_s == 3'(i)) && (reg_s == REG_TCON);
      wr_presc_s[i] = MemWrite && ch_hit_s && (ch_s == 3'(i)) && (reg_s == REG_PRESC);
      flag_clr_s[i] = (wr_tcon_s[i] && Write_data[2]) ||
                      (MemWrite && status_hit_s && Write_data[i]);
      // A TCON write that drops EN stops the count on that very edge
      tick_s[i]     = en_r[i] && (pcnt_r[i] == presc_r[i]) &&
                      !(wr_tcon_s[i] && !Write_data[0]);
      // A TL write consumes the tick, so it cannot overflow as well
      ovf_s[i]      = tick_s[i] && (tl_r[i] == CNT_ONES) && !wr_tl_s[i];
    end
  end

  // Per-channel next-state: bus writes take priority over counting
  always_comb begin
    th_nxt_s    = th_r;
    tl_nxt_s    = tl_r;
    presc_nxt_s = presc_r;
    pcnt_nxt_s  = pcnt_r;
    en_nxt_s    = en_r;
    ie_nxt_s    = ie_r;
    os_nxt_s    = os_r;
    flag_nxt_s  = flag_r;
    irq_nxt_s   = {N_TIMERS{1'b0}};
    for (int i = 0; i < N_TIMERS; i++) begin
      th_nxt_s[i]    = wr_th_s[i] ? Write_data[CNT_W-1:0] : th_r[i];
      presc_nxt_s[i] = wr_presc_s[i] ? Write_data[PRESC_W-1:0] : presc_r[i];

      // Overflow reloads from the TH held before this edge
      if (wr_tl_s[i]) begin
        tl_nxt_s[i] = Write_data[CNT_W-1:0];
      end else if (ovf_s[i]) begin
        tl_nxt_s[i] = th_r[i];
      end else if (tick_s[i]) begin
        tl_nxt_s[i] = tl_r[i] + CNT_W'(1);
      end else begin
        tl_nxt_s[i] = tl_r[i];
      end

      if (wr_tcon_s[i]) begin
        en_nxt_s[i] = Write_data[0];
        ie_nxt_s[i] = Write_data[1];
        os_nxt_s[i] = Write_data[3];
      end else if (ovf_s[i] && os_r[i]) begin
        en_nxt_s[i] = 1'b0;
        ie_nxt_s[i] = ie_r[i];
        os_nxt_s[i] = os_r[i];
      end else begin
        en_nxt_s[i] = en_r[i];
        ie_nxt_s[i] = ie_r[i];
        os_nxt_s[i] = os_r[i];
      end

      // Overflow beats a simultaneous write-1-to-clear
      if (ovf_s[i]) begin
        flag_nxt_s[i] = 1'b1;
      end else if (flag_clr_s[i]) begin
        flag_nxt_s[i] = 1'b0;
      end else begin
        flag_nxt_s[i] = flag_r[i];
      end

      if (!en_r[i] || !en_nxt_s[i] || wr_tl_s[i] || wr_presc_s[i] || tick_s[i]) begin
        pcnt_nxt_s[i] = {PRESC_W{1'b0}};
      end else begin
        pcnt_nxt_s[i] = pcnt_r[i] + PRESC_W'(1);
      end

      irq_nxt_s[i] = flag_nxt_s[i] && ie_nxt_s[i];
    end
  end

  // State and interrupt registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_TIMERS; i++) begin
        th_r[i]    <= {CNT_W{1'b0}};
        tl_r[i]    <= {CNT_W{1'b0}};
        presc_r[i] <= {PRESC_W{1'b0}};
        pcnt_r[i]  <= {PRESC_W{1'b0}};
      end
      en_r      <= {N_TIMERS{1'b0}};
      ie_r      <= {N_TIMERS{1'b0}};
      os_r      <= {N_TIMERS{1'b0}};
      flag_r    <= {N_TIMERS{1'b0}};
      irq_vec_r <= {N_TIMERS{1'b0}};
      irqout_r  <= 1'b0;
    end else begin
      for (int i = 0; i < N_TIMERS; i++) begin
        th_r[i]    <= th_nxt_s[i];
        tl_r[i]    <= tl_nxt_s[i];
        presc_r[i] <= presc_nxt_s[i];
        pcnt_r[i]  <= pcnt_nxt_s[i];
      end
      en_r      <= en_nxt_s;
      ie_r      <= ie_nxt_s;
      os_r      <= os_nxt_s;
      flag_r    <= flag_nxt_s;
      irq_vec_r <= irq_nxt_s;
      irqout_r  <= |irq_nxt_s;
    end
  end

  // Per-channel readback word, zero-extended
  always_comb begin
    for (int i = 0; i < N_TIMERS; i++) begin
      ch_rd_s[i] = 32'h0000_0000;
      case (reg_s)
        REG_TH:    ch_rd_s[i][CNT_W-1:0]   = th_r[i];
        REG_TL:    ch_rd_s[i][CNT_W-1:0]   = tl_r[i];
        REG_TCON:  ch_rd_s[i][3:0]         = {os_r[i], flag_r[i], ie_r[i], en_r[i]};
        REG_PRESC: ch_rd_s[i][PRESC_W-1:0] = presc_r[i];
        default:   ch_rd_s[i]              = 32'h0000_0000;
      endcase
    end
  end

  // Read mux: zero unless a mapped register is read
  always_comb begin
    rd_s = 32'h0000_0000;
    if (MemRead && status_hit_s) begin
      rd_s[N_TIMERS-1:0] = flag_r;
    end else if (MemRead && ch_hit_s) begin
      for (int i = 0; i < N_TIMERS; i++) begin
        rd_s = rd_s | ((ch_s == 3'(i)) ? ch_rd_s[i] : 32'h0000_0000);
      end
    end else begin
      rd_s = 32'h0000_0000;
    end
  end

  assign Read_data = rd_s;
  assign irq_vec   = irq_vec_r;
  assign irqout    = irqout_r;

endmodule
